// File: rtl/endian_swap_pkg.sv
// Shared mode encoding and bit-source mapping for endian_swap_stream.
package endian_swap_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_BITREV   = 2'd1,
    MODE_LANESWAP = 2'd2,
    MODE_LANEREV  = 2'd3
  } mode_t;

  // Returns which input bit feeds output bit i; loops over constant widths fold away.
  function automatic int unsigned src_bit(input mode_t       mode,
                                          input int unsigned i,
                                          input int unsigned data_w,
                                          input int unsigned lane_w);
    int unsigned lanes;
    int unsigned lane;
    int unsigned bit_idx;
    lanes   = data_w / lane_w;
    lane    = i / lane_w;
    bit_idx = i % lane_w;
    case (mode)
      MODE_BITREV:   return data_w - 1 - i;
      MODE_LANESWAP: return (lanes - 1 - lane) * lane_w + bit_idx;
      MODE_LANEREV:  return lane * lane_w + (lane_w - 1 - bit_idx);
      default:       return i;
    endcase
  endfunction

endpackage

// File: rtl/endian_skid_buf.sv
// Two-entry registered valid/ready buffer; in_ready depends only on local state.
module endian_skid_buf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // An accept always sees SKID empty, so SKID->OUT refill and accept never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (in_fire) begin
      if (!out_valid || out_fire) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (out_fire) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/endian_swap_stream.sv
// Per-beat bit/lane reordering stage on a valid/ready stream.
// Define ENDIAN_SWAP_STATS_EN to add the saturating stat_beats transfer counter.
module endian_swap_stream
  import endian_swap_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef ENDIAN_SWAP_STATS_EN
  ,
  output logic [15:0]       stat_beats
`endif
);

  localparam int unsigned IDX_W = $clog2(DATA_W);

  if ((DATA_W % LANE_W) != 0 || LANE_W < 2) begin : g_bad_cfg
    $fatal(1, "endian_swap_stream: DATA_W must be a multiple of LANE_W and LANE_W >= 2");
  end

  logic [DATA_W-1:0] in_xf;

  // Transform before storage so buffered beats keep the mode they arrived with.
  always_comb begin
    in_xf = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      in_xf[i] = in_data[IDX_W'(src_bit(mode_t'(in_mode), i, DATA_W, LANE_W))];
    end
  end

  endian_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_xf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

`ifdef ENDIAN_SWAP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
    end else if (out_valid && out_ready && stat_beats != '1) begin
      stat_beats <= stat_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_endian_swap_stream.sv
// Directed, table-driven bench for endian_swap_stream (DATA_W=32, LANE_W=8).
module tb_endian_swap_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef ENDIAN_SWAP_STATS_EN
  logic [15:0] stat_beats;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[8];

  endian_swap_stream #(
    .DATA_W(32),
    .LANE_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef ENDIAN_SWAP_STATS_EN
    ,
    .stat_beats(stat_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'd1, 32'h00000001, 32'h80000000};
    vecs[1] = '{2'd2, 32'h12345678, 32'h78563412};
    vecs[2] = '{2'd3, 32'h01020304, 32'h8040C020};
    vecs[3] = '{2'd0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4] = '{2'd1, 32'h12345678, 32'h1E6A2C48};
    vecs[5] = '{2'd3, 32'hFF00A5F0, 32'hFF00A50F};
    vecs[6] = '{2'd2, 32'hDEADBEEF, 32'hEFBEADDE};
    vecs[7] = '{2'd0, 32'h00000000, 32'h00000000};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Single isolated beats: 1-cycle latency, valid for exactly one cycle.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_mode = vecs[i].mode; in_data = vecs[i].din;
      step();
      in_valid = 1'b0; in_mode = 2'd0; in_data = '0;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
      step();
      chk($sformatf("vec%0d_gone", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back with rotating modes.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_mode = vecs[i].mode; in_data = vecs[i].din;
      step();
      chk($sformatf("b2b%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("b2b%0d_data", i), out_data, vecs[i].dout);
      chk($sformatf("b2b%0d_rdy", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_end", {31'd0, out_valid}, 32'd0);

    // Backpressure: A, B accepted, C held until space frees.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd2; in_data = 32'h11223344;
    step();
    chk("bp_a_rdy", {31'd0, in_ready}, 32'd1);
    chk("bp_a_out", out_data, 32'h44332211);
    in_mode = 2'd1; in_data = 32'h00000003;
    step();
    chk("bp_b_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp_b_out", out_data, 32'h44332211);
    in_mode = 2'd3; in_data = 32'h80402010;
    step();
    chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_out", out_data, 32'h44332211);
    out_ready = 1'b1;
    step();
    chk("bp_drain_a", out_data, 32'hC0000000);
    chk("bp_rdy_back", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_drain_b", out_data, 32'h01020408);
    chk("bp_c_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd0; in_data = 32'hCAFEF00D;
    step();
    in_data = 32'h0BADBEEF;
    step();
    in_valid = 1'b0;
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_rdy", {31'd0, in_ready}, 32'd1);
    chk("ar_data", out_data, 32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 2'd2; in_data = 32'hA1B2C3D4;
    step();
    in_valid = 1'b0;
    chk("ar_first_data", out_data, 32'hD4C3B2A1);
    chk("ar_first_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("ar_no_stale", {31'd0, out_valid}, 32'd0);

`ifdef ENDIAN_SWAP_STATS_EN
    chk("st_small", {16'd0, stat_beats}, 32'd1);
    in_valid = 1'b1; in_mode = 2'd0;
    repeat (70000) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("st_sat", {16'd0, stat_beats}, 32'h0000FFFF);
    rst_n = 1'b0;
    #1;
    chk("st_clr", {16'd0, stat_beats}, 32'd0);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
